// File: rtl/piso_serializer_controller_pkg.sv
// Shared types and counter-width helpers for the PISO serializer controller.
// Widths are computed from the instance parameters so every instance sizes its own counters.
package piso_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_WIDTH   = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 4;

    // bit_cnt must hold 0..data_width-1; keep at least one bit for a 1-bit frame
    function automatic int bit_cnt_width(input int data_width);
        return (data_width > 1) ? $clog2(data_width) : 1;
    endfunction

    function automatic int clk_cnt_width(input int clks_per_bit);
        return $clog2(clks_per_bit + 1);
    endfunction

endpackage

// File: rtl/piso_serializer_controller_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last clock of a bit.
module piso_bit_timer
    import piso_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = clk_cnt_width(DEFAULT_CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_r;

    assign tc  = (cnt_r == LAST_CNT);
    assign cnt = cnt_r;

    // Counter register: clear wins over counting, wrap to zero on terminal count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            if (tc) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/piso_serializer_controller.sv
// Sequencer for an 8-bit PISO: byte handshake, load/shift strobes and per-bit hold timing.
// Strobes are decoded from registered state and gated by Enable_In, Abort_In and Reset_In.
module piso_serializer_controller
    import piso_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic                  Enable_In,
    input  logic                  Abort_In,
    input  logic [DATA_WIDTH-1:0] Data_In,
    input  logic                  Data_Valid_In,
    output logic                  Data_Ready_Out,
    output logic                  PISO_Enable_Out,
    output logic                  PISO_Load_Out,
    output logic                  PISO_Shift_Out,
    output logic [DATA_WIDTH-1:0] PISO_Data_Out,
    output logic                  Serial_Valid_Out,
    output logic                  Frame_Start_Out,
    output logic                  Frame_Done_Out,
    output logic                  Busy_Out
);

    localparam int BIT_CNT_W = bit_cnt_width(DATA_WIDTH);
    localparam int CLK_CNT_W = clk_cnt_width(CLKS_PER_BIT);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    state_t                  state_r;
    state_t                  state_nx_s;
    logic [BIT_CNT_W-1:0]    bit_cnt_r;
    logic [DATA_WIDTH-1:0]   hold_r;
    logic [CLK_CNT_W-1:0]    clk_cnt_s;
    logic                    clk_tc_s;
    logic                    timer_en_s;
    logic                    timer_clr_s;
    logic                    last_bit_s;
    logic                    capture_s;
    logic                    ready_s;
    logic                    load_s;
    logic                    shift_s;
    logic                    serial_valid_s;
    logic                    start_s;
    logic                    done_s;

    assign last_bit_s  = (bit_cnt_r == LAST_BIT);
    assign timer_en_s  = Enable_In && (state_r == SHIFT) && !Abort_In;
    assign timer_clr_s = Enable_In && (Abort_In || (state_r != SHIFT));

    piso_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CLK_CNT_W)
    ) u_bit_timer (
        .clk (Clk_In),
        .rst (Reset_In),
        .en  (timer_en_s),
        .clr (timer_clr_s),
        .cnt (clk_cnt_s),
        .tc  (clk_tc_s)
    );

    // State register
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Bit index: cleared outside SHIFT or on abort, advances on each bit-period terminal count
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            bit_cnt_r <= '0;
        end else if (timer_clr_s) begin
            bit_cnt_r <= '0;
        end else if (timer_en_s && clk_tc_s) begin
            if (last_bit_s) begin
                bit_cnt_r <= '0;
            end else begin
                bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
            end
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Holding register presented to the PISO parallel input
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            hold_r <= '0;
        end else if (capture_s) begin
            hold_r <= Data_In;
        end else begin
            hold_r <= hold_r;
        end
    end

    // Next-state and strobe decode; with Enable_In low everything holds and all strobes stay low
    always_comb begin
        state_nx_s     = state_r;
        capture_s      = 1'b0;
        ready_s        = 1'b0;
        load_s         = 1'b0;
        shift_s        = 1'b0;
        serial_valid_s = 1'b0;
        start_s        = 1'b0;
        done_s         = 1'b0;
        if (Enable_In) begin
            case (state_r)
                IDLE: begin
                    ready_s = !Abort_In;
                    if (Abort_In) begin
                        state_nx_s = IDLE;
                    end else if (Data_Valid_In) begin
                        capture_s  = 1'b1;
                        state_nx_s = LOAD;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                LOAD: begin
                    if (Abort_In) begin
                        state_nx_s = IDLE;
                    end else begin
                        load_s     = 1'b1;
                        state_nx_s = SHIFT;
                    end
                end
                SHIFT: begin
                    serial_valid_s = 1'b1;
                    start_s = !Abort_In && (bit_cnt_r == '0) && (clk_cnt_s == '0);
                    if (Abort_In) begin
                        state_nx_s = IDLE;
                    end else if (clk_tc_s && last_bit_s) begin
                        // last clock of the frame doubles as the accept slot for back-to-back bytes
                        done_s  = 1'b1;
                        ready_s = 1'b1;
                        if (Data_Valid_In) begin
                            capture_s  = 1'b1;
                            state_nx_s = LOAD;
                        end else begin
                            state_nx_s = IDLE;
                        end
                    end else begin
                        shift_s    = clk_tc_s;
                        state_nx_s = SHIFT;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                end
            endcase
        end else begin
            state_nx_s = state_r;
        end
    end

    assign Data_Ready_Out   = ready_s        & ~Reset_In;
    assign PISO_Enable_Out  = Enable_In      & ~Reset_In;
    assign PISO_Load_Out    = load_s         & ~Reset_In;
    assign PISO_Shift_Out   = shift_s        & ~Reset_In;
    assign Serial_Valid_Out = serial_valid_s & ~Reset_In;
    assign Frame_Start_Out  = start_s        & ~Reset_In;
    assign Frame_Done_Out   = done_s         & ~Reset_In;
    assign PISO_Data_Out    = hold_r;
    assign Busy_Out         = (state_r != IDLE);

endmodule

// File: tb/tb_piso_serializer_controller.sv
// Bench: two controllers (CLKS_PER_BIT 2 and 1) with a small PISO each, checked per cycle
// against a frame-position reference model plus directed and random stimulus.
module tb_piso_serializer_controller;

    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       en    [2];
    logic       abort [2];
    logic       valid [2];
    logic [7:0] din   [2];
    logic       rdy [2], pen [2], pld [2], psh [2], sv [2], fs [2], fd [2], bsy [2];
    logic [7:0] pdo [2];

    piso_serializer_controller #(.DATA_WIDTH(DW), .CLKS_PER_BIT(2)) dut0 (
        .Clk_In(clk), .Reset_In(rst), .Enable_In(en[0]), .Abort_In(abort[0]),
        .Data_In(din[0]), .Data_Valid_In(valid[0]), .Data_Ready_Out(rdy[0]),
        .PISO_Enable_Out(pen[0]), .PISO_Load_Out(pld[0]), .PISO_Shift_Out(psh[0]),
        .PISO_Data_Out(pdo[0]), .Serial_Valid_Out(sv[0]), .Frame_Start_Out(fs[0]),
        .Frame_Done_Out(fd[0]), .Busy_Out(bsy[0])
    );

    piso_serializer_controller #(.DATA_WIDTH(DW), .CLKS_PER_BIT(1)) dut1 (
        .Clk_In(clk), .Reset_In(rst), .Enable_In(en[1]), .Abort_In(abort[1]),
        .Data_In(din[1]), .Data_Valid_In(valid[1]), .Data_Ready_Out(rdy[1]),
        .PISO_Enable_Out(pen[1]), .PISO_Load_Out(pld[1]), .PISO_Shift_Out(psh[1]),
        .PISO_Data_Out(pdo[1]), .Serial_Valid_Out(sv[1]), .Frame_Start_Out(fs[1]),
        .Frame_Done_Out(fd[1]), .Busy_Out(bsy[1])
    );

    // Behavioural PISO driven by the controller strobes; serial output is bit 7
    logic [7:0] piso [2];
    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) piso[k] <= 8'h00;
            else if (pen[k] && pld[k]) piso[k] <= pdo[k];
            else if (pen[k] && psh[k]) piso[k] <= {piso[k][6:0], 1'b0};
        end
    end

    // Reference model: phase -1 = idle, 0 = load cycle, 1..DW*cpb = position within the frame
    int         cpb [2] = '{2, 1};
    int         phase [2];
    logic [7:0] mhold [2];
    bit         acc_flag [2];
    int         shift_cnt [2];
    int         checks = 0;
    int         errors = 0;

    task automatic check_value(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", tag, k, $time, got, exp);
        end
    endtask

    task automatic tick();
        int  nphase [2];
        logic [7:0] nhold [2];
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            int   t, fl, bitpos;
            bit   act, e_sv, e_ld, e_st, e_dn, e_sh, e_rd, accept;
            logic [7:0] b;
            if (rst) begin
                phase[k] = -1;
                mhold[k] = 8'h00;
            end
            t   = phase[k] - 1;
            fl  = DW * cpb[k];
            act = !rst && en[k] && !abort[k];
            e_sv = !rst && en[k] && (phase[k] >= 1);
            e_ld = act && (phase[k] == 0);
            e_st = act && (phase[k] == 1);
            e_dn = act && (phase[k] >= 1) && (t == fl - 1);
            e_sh = act && (phase[k] >= 1) && ((t % cpb[k]) == cpb[k] - 1) && ((t / cpb[k]) < DW - 1);
            e_rd = act && ((phase[k] == -1) || ((phase[k] >= 1) && (t == fl - 1)));
            check_value("ready", k, rdy[k], e_rd);
            check_value("piso_en", k, pen[k], !rst && en[k]);
            check_value("load", k, pld[k], e_ld);
            check_value("shift", k, psh[k], e_sh);
            check_value("serial_valid", k, sv[k], e_sv);
            check_value("frame_start", k, fs[k], e_st);
            check_value("frame_done", k, fd[k], e_dn);
            check_value("busy", k, bsy[k], phase[k] != -1);
            check_value("piso_data", k, pdo[k], mhold[k]);
            if (e_sv) begin
                b = mhold[k];
                bitpos = DW - 1 - (t / cpb[k]);
                check_value("serial_bit", k, piso[k][7], b[bitpos]);
            end
            if (!rst && psh[k]) shift_cnt[k]++;
            accept    = e_rd && valid[k];
            nphase[k] = phase[k];
            nhold[k]  = mhold[k];
            if (rst) begin
                nphase[k] = -1;
            end else if (en[k]) begin
                if (abort[k]) nphase[k] = -1;
                else if (phase[k] == -1) nphase[k] = accept ? 0 : -1;
                else if (t == fl - 1) nphase[k] = accept ? 0 : -1;
                else nphase[k] = phase[k] + 1;
                if (accept) begin
                    nhold[k] = din[k];
                    acc_flag[k] = 1'b1;
                end
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            phase[k] = nphase[k];
            mhold[k] = nhold[k];
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_accept(input int k);
        acc_flag[k] = 1'b0;
        for (int i = 0; i < 40 && !acc_flag[k]; i++) tick();
        check_value("accept_seen", k, acc_flag[k], 1'b1);
    endtask

    task automatic send(input int k, input logic [7:0] b);
        valid[k] = 1'b1;
        din[k]   = b;
        wait_accept(k);
        valid[k] = 1'b0;
        din[k]   = 8'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            en[k] = 1'b1; abort[k] = 1'b0; valid[k] = 1'b0; din[k] = 8'h00;
            phase[k] = -1; mhold[k] = 8'h00; acc_flag[k] = 1'b0; shift_cnt[k] = 0;
        end
        run(2);
        rst = 1'b0;
        run(2);

        // single frame, noise on Data_In while not valid
        send(0, 8'hA5);
        for (int i = 0; i < 20; i++) begin
            din[0] = 8'($urandom);
            tick();
        end

        // back-to-back with valid held high across the frame boundary
        send(0, 8'hFF);
        send(0, 8'h00);
        run(20);

        // enable dropped for 5 cycles at the start of bit 3
        send(0, 8'h96);
        run(7);
        en[0] = 1'b0;
        run(5);
        en[0] = 1'b1;
        run(20);

        // abort at bit 4 with valid still high, then the next byte
        valid[0] = 1'b1;
        din[0]   = 8'hC3;
        wait_accept(0);
        din[0] = 8'h3C;
        run(9);
        abort[0] = 1'b1;
        tick();
        abort[0] = 1'b0;
        wait_accept(0);
        valid[0] = 1'b0;
        run(20);

        // asynchronous reset between edges in the middle of a frame
        send(0, 8'h5A);
        run(6);
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_value("async_ready", k, rdy[k], 1'b0);
            check_value("async_piso_en", k, pen[k], 1'b0);
            check_value("async_serial_valid", k, sv[k], 1'b0);
            check_value("async_busy", k, bsy[k], 1'b0);
            check_value("async_piso_data", k, pdo[k], 8'h00);
        end
        tick();
        rst = 1'b0;
        run(3);

        // one clock per bit: 7 shift strobes for a single frame
        send(1, 8'h81);
        shift_cnt[1] = 0;
        run(12);
        check_value("shift_count", 1, shift_cnt[1], 7);

        // random traffic on both controllers
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                en[k]    = ($urandom_range(0, 9) != 0);
                abort[k] = ($urandom_range(0, 39) == 0);
                valid[k] = $urandom_range(0, 1) != 0;
                din[k]   = 8'($urandom);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            en[k] = 1'b1; abort[k] = 1'b0; valid[k] = 1'b0;
        end
        run(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
